fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the 1-cycle instruction memory and
// buffers results in a tagged FIFO. Build option FETCH_PERF_EN adds counters.
module fetch_unit #(
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned PC_W       = 10,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PC_W-1:0] PC0 = PC_W'(RESET_PC);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    inflight_pc;
    logic               inflight;
    logic [PC_W-1:0]    pc_mem   [FIFO_DEPTH];
    logic [INSTR_W-1:0] data_mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [CW:0]        used;
    logic               empty;
    logic               issue;
    logic               push;
    logic               pop;

    // Credit check, handshake decode and combinational head-of-FIFO outputs
    always_comb begin
        used        = {1'b0, count} + {{CW{1'b0}}, inflight};
        empty       = (count == '0);
        issue       = !rst && !redirect && !halt && (used < DEPTH);
        push        = inflight && !redirect;
        instr_valid = !empty && !redirect;
        pop         = instr_valid && instr_ready;
        imem_req    = issue;
        imem_addr   = fetch_pc;
        instr       = empty ? '0 : data_mem[rd_ptr];
        instr_pc    = empty ? '0 : pc_mem[rd_ptr];
    end

    // PC and outstanding-read tracking; a redirect kills the pending read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= PC0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; cleared outright on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            data_mem[wr_ptr] <= imem_data;
        end
    end

`ifdef FETCH_PERF_EN
    // Fetched/flushed instruction counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)     perf_fetched <= perf_fetched + 32'd1;
            if (redirect) perf_flushed <= perf_flushed + 32'(used);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line, backpressure, redirect,
// wrap-around, halt and asynchronous reset with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic        redirect = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: mem[a] = 0x1000_0000 + a
    always @(posedge clk) begin
        if (imem_req) imem_data <= 32'h1000_0000 + 32'(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        tick();
        settle();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic wait_pop(input string tag, input logic [9:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            adv();
            if (instr_valid) begin
                found = 1'b1;
                check({tag, "_pc"}, 32'(instr_pc), 32'(pc));
                check({tag, "_in"}, instr, 32'h1000_0000 + 32'(pc));
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        settle();
        settle();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_pf", perf_fetched, 32'd0);
`endif

        // Straight-line fetch
        tick();
        rst = 1'b0;
        settle();
        check("sl_req0", 32'(imem_req), 32'd1);
        check("sl_addr0", 32'(imem_addr), 32'd0);
        check("sl_v0", 32'(instr_valid), 32'd0);
        adv();
        check("sl_addr1", 32'(imem_addr), 32'd1);
        check("sl_v1", 32'(instr_valid), 32'd0);
        adv();
        check("sl_v2", 32'(instr_valid), 32'd1);
        check("sl_in2", instr, 32'h1000_0000);
        check("sl_pc2", 32'(instr_pc), 32'd0);
        adv();
        check("sl_v3", 32'(instr_valid), 32'd1);
        check("sl_pc3", 32'(instr_pc), 32'd1);
        wait_pop("sl2", 10'd2);
        wait_pop("sl3", 10'd3);

        // Backpressure: two entries held, no further requests
        instr_ready = 1'b0;
        do_reset();
        check("bp_req0", 32'(imem_req), 32'd1);
        adv();
        for (int i = 0; i < 6; i++) begin
            adv();
            check("bp_req", 32'(imem_req), 32'd0);
            check("bp_pc", 32'(instr_pc), 32'd0);
        end
        tick();
        instr_ready = 1'b1;
        settle();
        check("bp_pop0", 32'(instr_pc), 32'd0);
        check("bp_v0", 32'(instr_valid), 32'd1);
        adv();
        check("bp_pop1", 32'(instr_pc), 32'd1);
        check("bp_in1", instr, 32'h1000_0001);
        adv();
        check("bp_gap", 32'(instr_valid), 32'd0);
        wait_pop("bp2", 10'd2);

        // Redirect with one entry buffered and one read in flight
        instr_ready = 1'b0;
        do_reset();
        adv();
        tick();
        redirect = 1'b1;
        redirect_pc = 10'h040;
        settle();
        check("rd_v", 32'(instr_valid), 32'd0);
        check("rd_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        instr_ready = 1'b1;
        settle();
        check("rd_addr", 32'(imem_addr), 32'h040);
        check("rd_req1", 32'(imem_req), 32'd1);
`ifdef FETCH_PERF_EN
        check("rd_pfl", perf_flushed, 32'd2);
        check("rd_pf", perf_fetched, 32'd1);
`endif
        wait_pop("rd", 10'h040);

        // Wrap-around of the PC
        tick();
        redirect = 1'b1;
        redirect_pc = 10'h3FE;
        settle();
        check("wr_v", 32'(instr_valid), 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        check("wr_addr", 32'(imem_addr), 32'h3FE);
        wait_pop("wr0", 10'h3FE);
        wait_pop("wr1", 10'h3FF);
        wait_pop("wr2", 10'h000);
        wait_pop("wr3", 10'h001);

        // Halt with one read in flight
        tick();
        redirect = 1'b1;
        redirect_pc = 10'h100;
        settle();
        tick();
        redirect = 1'b0;
        settle();
        check("hl_req0", 32'(imem_req), 32'd1);
        check("hl_addr0", 32'(imem_addr), 32'h100);
        tick();
        halt = 1'b1;
        settle();
        check("hl_req1", 32'(imem_req), 32'd0);
        check("hl_addr1", 32'(imem_addr), 32'h101);
        adv();
        check("hl_v", 32'(instr_valid), 32'd1);
        check("hl_pc", 32'(instr_pc), 32'h100);
        check("hl_req2", 32'(imem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            adv();
            check("hl_hold", 32'(imem_addr), 32'h101);
            check("hl_idle", 32'(imem_req), 32'd0);
        end
        tick();
        halt = 1'b0;
        settle();
        check("hl_res_req", 32'(imem_req), 32'd1);
        check("hl_res_addr", 32'(imem_addr), 32'h101);
        wait_pop("hl", 10'h101);

        // Asynchronous reset while the FIFO is full
        tick();
        instr_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 10'h200;
        settle();
        tick();
        redirect = 1'b0;
        settle();
        adv();
        adv();
        adv();
        check("ar_full_v", 32'(instr_valid), 32'd1);
        check("ar_full_pc", 32'(instr_pc), 32'h200);
        check("ar_full_req", 32'(imem_req), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("ar_v", 32'(instr_valid), 32'd0);
        check("ar_addr", 32'(imem_addr), 32'd0);
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_ipc", 32'(instr_pc), 32'd0);
`ifdef FETCH_PERF_EN
        check("ar_pf", perf_fetched, 32'd0);
`endif
        #1;
        rst = 1'b0;
        settle();
        check("ar_v1", 32'(instr_valid), 32'd0);
        check("ar_req1", 32'(imem_req), 32'd1);
        check("ar_addr1", 32'(imem_addr), 32'd0);
        tick();
        instr_ready = 1'b1;
        settle();
        wait_pop("ar", 10'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
